// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: streams two WIDTH-bit operands LSB-first through
// one shared full-adder cell, with a registered carry, and presents {cout,sum}.

module fulladder (
    output logic s,
    output logic c1,
    input  logic a,
    input  logic b,
    input  logic c0
);
    assign s  = a ^ b ^ c0;
    assign c1 = (a & b) | (c0 & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic             fa_s, fa_c1;
    logic [WIDTH-1:0] res_shift;

    fulladder u_fa (
        .s  (fa_s),
        .c1 (fa_c1),
        .a  (sa_q[0]),
        .b  (sb_q[0]),
        .c0 (carry_q)
    );

    // Result fills from the MSB down so the first-processed bit ends up at bit 0.
    always_comb begin
        res_shift            = res_q >> 1;
        res_shift[WIDTH-1]   = fa_s;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    sa_d    = a;
                    sb_d    = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    res_d   = '0;
                end
            end
            RUN: begin
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                carry_d = fa_c1;
                res_d   = res_shift;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    sum_d   = res_shift;
                    cout_d  = fa_c1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboarded bench: directed adds on WIDTH=8 and WIDTH=1 instances; monitors
// pop expected {cout,sum} on every done pulse.

module tb_serial_add_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;
    logic       start1 = 1'b0, cin1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    int tests = 0, fails = 0, cyc = 0, done_cnt8 = 0;
    logic [8:0] q8[$];
    logic [1:0] q1[$];
    localparam logic [1:0] FA_TT [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));
    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done8) begin
            done_cnt8++;
            if (q8.size() == 0) check("done8_unexpected", 1, 0);
            else check("res8", {cout8, sum8}, q8.pop_front());
        end
        if (done1) begin
            if (q1.size() == 0) check("done1_unexpected", 1, 0);
            else check("res1", {cout1, sum1}, q1.pop_front());
        end
    end

    task automatic add8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic [7:0] es, input logic ec, input bit pulse);
        logic [7:0] prev;
        int n, busy_cnt, d0;
        bit held;
        @(negedge clk);
        a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
        q8.push_back({ec, es});
        prev = sum8;
        d0 = done_cnt8;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
        busy_cnt = int'(busy8);
        held = (sum8 == prev);
        n = 0;
        while (n < 20 && !done8) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (pulse && n == 2) start8 = 1'b1;
            if (pulse && n == 3) start8 = 1'b0;
            busy_cnt += int'(busy8);
            if (!done8 && sum8 != prev) held = 1'b0;
        end
        check("done_latency", n, 8);
        check("busy_cycles", busy_cnt, 9);
        check("sum_held_in_run", held, 1);
        if (pulse) start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        check("idle_after_done", busy8, 0);
        @(negedge clk);
        check("still_idle", busy8, 0);
        check("single_done", done_cnt8 - d0, 1);
    endtask

    initial begin
        int t0, tprev, lim;
        #12;
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_sum", {cout8, sum8}, 0);
        check("rst_w1", {busy1, done1, cout1, sum1}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        add8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0);
        add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
        add8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 0);
        add8(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 0);
        add8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1);

        // start held high: one result every WIDTH+2 cycles
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        repeat (3) q8.push_back({1'b0, 8'h02});
        tprev = 0;
        for (int k = 0; k < 3; k++) begin
            lim = 0;
            @(negedge clk);
            while (!done8 && lim < 30) begin @(negedge clk); lim++; end
            check("cont_done_seen", done8, 1);
            t0 = cyc;
            if (k > 0) check("cont_period", t0 - tprev, 10);
            tprev = t0;
        end
        start8 = 1'b0;
        repeat (3) @(negedge clk);

        // async reset mid-RUN discards the add in flight
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0; start8 = 1'b1;
        t0 = done_cnt8;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy8, 0);
        check("mid_rst_done", done8, 0);
        check("mid_rst_sum", sum8, 0);
        check("mid_rst_cout", cout8, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("no_done_after_rst", done_cnt8 - t0, 0);
        add8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 0);

        // WIDTH=1: full-adder truth table
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a1 = i[2]; b1 = i[1]; cin1 = i[0]; start1 = 1'b1;
            q1.push_back(FA_TT[i]);
            @(posedge clk);
            @(negedge clk);
            start1 = 1'b0;
            lim = 0;
            while (!done1 && lim < 10) begin @(negedge clk); lim++; end
            check("w1_latency", lim, 1);
        end
        repeat (3) @(negedge clk);

        check("q8_drained", q8.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
